// File: rtl/data_cache_if.sv
// data_cache_if: core load/store request bus plus the backing-memory
// handshake of the data cache.
//   slave  : the cache's view (takes core requests, drives the memory side)
//   master : the environment's view (core + backing memory)
// Core side  : req_valid, req_we, req_addr, req_wdata, addr_mode, invalidate -> cache
//              rdata, stall                                                 <- cache
// Memory side: mem_req, mem_we, mem_addr, mem_wdata, mem_be                  <- cache
//              mem_ready, mem_rdata                                          -> cache
interface data_cache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  addr_mode;
    logic                  invalidate;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, addr_mode, invalidate,
        output rdata, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, addr_mode, invalidate,
        input  rdata, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// One 32-bit word per line. Read hits return combinationally with no stall;
// read misses and all stores stall the core while a single-word handshake
// runs against backing memory. Word and zero-extended byte accesses.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset (FSM to IDLE, all lines invalid)
//   bus  - data_cache_if.slave (core request bus + memory handshake)
//   access_count, miss_count - 32-bit statistics counters, present only when
//                              the DCACHE_STATS_EN macro is defined
//
// Build option: `define DCACHE_STATS_EN adds the statistics counters.
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8
) (
    input  logic        clk,
    input  logic        rst,
    data_cache_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] access_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_MISS  = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS];

    logic [1:0]            offset;
    logic [IDX_W-1:0]      index;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] line;
    logic [7:0]            line_byte;
    logic                  lookup;
    logic                  hit;
    logic                  is_load;
    logic [3:0]            wr_be;

    assign offset  = bus.req_addr[1:0];
    assign index   = bus.req_addr[IDX_W+1:2];
    assign tag     = bus.req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign line    = data_mem[index];
    // lookup ignores invalidate; a same-cycle invalidate only matters in IDLE
    assign lookup  = valid[index] && (tag_mem[index] == tag);
    assign hit     = lookup && !bus.invalidate;
    assign is_load = bus.req_valid && !bus.req_we;
    assign wr_be   = bus.addr_mode ? (4'b0001 << offset) : 4'b1111;

    always_comb begin
        case (offset)
            2'd0:    line_byte = line[7:0];
            2'd1:    line_byte = line[15:8];
            2'd2:    line_byte = line[23:16];
            default: line_byte = line[31:24];
        endcase
    end

    // Address and write data follow the held request; only the strobes are
    // qualified by state.
    assign bus.mem_addr  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata = bus.addr_mode ? {4{bus.req_wdata[7:0]}} : bus.req_wdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bus.stall  = 1'b0;
        bus.rdata  = '0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.mem_be  = 4'b0000;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        bus.stall = 1'b1;
                        state_nxt = WRITE_THRU;
                    end else if (hit) begin
                        bus.rdata = bus.addr_mode ? {{(DATA_WIDTH-8){1'b0}}, line_byte} : line;
                    end else begin
                        bus.stall = 1'b1;
                        state_nxt = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                bus.mem_req = 1'b1;
                bus.mem_be  = 4'b1111;
                bus.stall   = 1'b1;
                if (bus.mem_ready) state_nxt = IDLE;
            end
            WRITE_THRU: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.mem_be  = wr_be;
                // the core advances in the same cycle the write is accepted
                bus.stall   = !bus.mem_ready;
                if (bus.mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (state == IDLE && bus.invalidate) begin
            valid <= '0;
        end else if (state == READ_MISS && bus.mem_ready) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag/data arrays are not reset; valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (state == READ_MISS && bus.mem_ready) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= bus.mem_rdata;
        end else if (state == WRITE_THRU && bus.mem_ready && lookup) begin
            // store hit: merge the written bytes, store miss leaves the line alone
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_mem[index][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            access_count <= '0;
            miss_count   <= '0;
        end else begin
            if ((state == IDLE && is_load && hit) ||
                (state == WRITE_THRU && bus.mem_ready))
                access_count <= access_count + 32'd1;
            if (state == IDLE && is_load && !hit)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache. Acts as both core and
// backing memory; a behavioural cache/memory model predicts rdata, stall
// length and the memory transaction for every access.
module tb_data_cache;
    localparam int SETS = 8;

    logic clk;
    logic rst;
    data_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
`ifdef DCACHE_STATS_EN
    logic [31:0] access_count, miss_count;
`endif

    data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(SETS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DCACHE_STATS_EN
        ,
        .access_count(access_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    logic [31:0] mem [logic [31:0]];
    bit          mv  [SETS];
    logic [31:0] mt  [SETS];
    logic [31:0] md  [SETS];
    int unsigned m_acc, m_miss;

    typedef struct {
        logic [31:0] rd;
        int          stall_cyc;
        int          txns;
        logic [31:0] m_addr;
        logic [3:0]  m_be;
        logic        m_we;
        logic [31:0] m_wdata;
        bit          timeout;
    } obs_t;

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
        m_acc  = 0;
        m_miss = 0;
    endtask

    task automatic predict(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input bit mode, input bit inv, input int lat, output obs_t e);
        int          idx;
        int          off;
        logic [31:0] tg;
        logic [31:0] w;
        logic [31:0] mask;
        bit          h;
        idx = int'((addr / 4) % SETS);
        off = int'(addr % 4);
        tg  = addr / (4 * SETS);
        w   = addr / 4;
        e.rd = 0; e.stall_cyc = 0; e.txns = 0; e.m_addr = w * 4;
        e.m_be = 4'h0; e.m_we = 1'b0; e.m_wdata = 0; e.timeout = 1'b0;
        if (!mem.exists(w)) mem[w] = $urandom;
        h = mv[idx] && (mt[idx] == tg) && !inv;
        if (inv) for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
        if (!we) begin
            if (!h) begin
                md[idx] = mem[w]; mt[idx] = tg; mv[idx] = 1'b1;
                e.stall_cyc = lat + 2; e.txns = 1; e.m_be = 4'hF;
                m_miss++;
            end
            e.rd = mode ? ((md[idx] >> (8 * off)) & 32'hFF) : md[idx];
        end else begin
            if (mode) begin
                mask      = 32'hFF << (8 * off);
                e.m_be    = 4'(1 << off);
                e.m_wdata = {4{wd[7:0]}};
            end else begin
                mask      = 32'hFFFF_FFFF;
                e.m_be    = 4'hF;
                e.m_wdata = wd;
            end
            mem[w] = (mem[w] & ~mask) | (e.m_wdata & mask);
            if (h) md[idx] = (md[idx] & ~mask) | (e.m_wdata & mask);
            e.stall_cyc = lat + 1; e.txns = 1; e.m_we = 1'b1;
        end
        m_acc++;
    endtask

    // Drive one access (starting and ending at a negedge), answering the
    // memory handshake with mem_ready 'lat' cycles after mem_req rises.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input bit mode, input bit inv, input int lat, output obs_t o);
        int rq;
        bit done;
        bit prev_req;
        rq = 0; done = 1'b0; prev_req = 1'b0;
        o.rd = 0; o.stall_cyc = 0; o.txns = 0; o.m_addr = 0; o.m_be = 0;
        o.m_we = 0; o.m_wdata = 0; o.timeout = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wd; bus.addr_mode = mode; bus.invalidate = inv;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (bus.mem_req) begin
                if (!prev_req) begin
                    o.txns++;
                    o.m_addr = bus.mem_addr; o.m_be = bus.mem_be;
                    o.m_we = bus.mem_we; o.m_wdata = bus.mem_wdata;
                end
                rq++;
                bus.mem_ready = (rq > lat);
                bus.mem_rdata = bus.mem_ready ? mem[addr / 4] : $urandom;
            end else begin
                rq = 0;
                bus.mem_ready = 1'b0;
            end
            prev_req = bus.mem_req;
            #1;
            if (bus.stall) o.stall_cyc++;
            else begin o.rd = bus.rdata; done = 1'b1; end
            @(posedge clk);
            @(negedge clk);
            bus.invalidate = 1'b0;
            bus.mem_ready  = 1'b0;
        end
        if (!done) o.timeout = 1'b1;
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.addr_mode = 0; bus.invalidate = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_clear();
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.mem_be !== 4'b0) begin n_fail++; $display("FAIL reset_mem_be: got %b want 0000", bus.mem_be); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        obs_t e, o;
        mem[32'h10 / 4] = 32'hDEADBEEF;
        predict(0, 32'h10, 0, 0, 0, 2, e);
        do_access(0, 32'h10, 0, 0, 0, 2, o);
        n_checks++; if (o.stall_cyc !== 4) begin n_fail++; $display("FAIL miss_stall: got %0d want 4", o.stall_cyc); end
        n_checks++; if (o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_rdata: got %h want deadbeef", o.rd); end
        n_checks++; if (o.txns !== 1 || o.m_addr !== 32'h10 || o.m_be !== 4'hF || o.m_we !== 1'b0) begin
            n_fail++; $display("FAIL miss_memreq: txns %0d addr %h be %b we %b want 1 10 1111 0", o.txns, o.m_addr, o.m_be, o.m_we); end
        predict(0, 32'h10, 0, 0, 0, 2, e);
        do_access(0, 32'h10, 0, 0, 0, 2, o);
        n_checks++; if (o.stall_cyc !== 0 || o.txns !== 0) begin
            n_fail++; $display("FAIL hit_nostall: stall %0d txns %0d want 0 0", o.stall_cyc, o.txns); end
        n_checks++; if (o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_rdata: got %h want deadbeef", o.rd); end
    endtask

    task automatic test_conflict();
        obs_t e, o;
        predict(0, 32'h30, 0, 0, 0, 1, e);
        do_access(0, 32'h30, 0, 0, 0, 1, o);
        n_checks++; if (o.txns !== 1 || o.m_addr !== 32'h30) begin
            n_fail++; $display("FAIL conflict_30: txns %0d addr %h want 1 30", o.txns, o.m_addr); end
        n_checks++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL conflict_30_rdata: got %h want %h", o.rd, e.rd); end
        predict(0, 32'h10, 0, 0, 0, 1, e);
        do_access(0, 32'h10, 0, 0, 0, 1, o);
        n_checks++; if (o.txns !== 1 || o.m_addr !== 32'h10) begin
            n_fail++; $display("FAIL conflict_10: txns %0d addr %h want 1 10", o.txns, o.m_addr); end
        n_checks++; if (o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL conflict_10_rdata: got %h want deadbeef", o.rd); end
    endtask

    task automatic test_byte_store();
        obs_t e, o;
        predict(1, 32'h13, 32'h5555_55AB, 1, 0, 1, e);
        do_access(1, 32'h13, 32'h5555_55AB, 1, 0, 1, o);
        n_checks++; if (o.m_be !== 4'b1000 || o.m_we !== 1'b1) begin
            n_fail++; $display("FAIL bstore_be: be %b we %b want 1000 1", o.m_be, o.m_we); end
        n_checks++; if (o.m_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL bstore_wdata: got %h want abababab", o.m_wdata); end
        n_checks++; if (o.stall_cyc !== 2 || o.m_addr !== 32'h10) begin
            n_fail++; $display("FAIL bstore_stall: stall %0d addr %h want 2 10", o.stall_cyc, o.m_addr); end
        predict(0, 32'h10, 0, 0, 0, 1, e);
        do_access(0, 32'h10, 0, 0, 0, 1, o);
        n_checks++; if (o.rd !== 32'hABADBEEF || o.stall_cyc !== 0) begin
            n_fail++; $display("FAIL bstore_merge: rd %h stall %0d want abadbeef 0", o.rd, o.stall_cyc); end
        predict(0, 32'h12, 0, 1, 0, 1, e);
        do_access(0, 32'h12, 0, 1, 0, 1, o);
        n_checks++; if (o.rd !== 32'h0000_00AD || o.stall_cyc !== 0) begin
            n_fail++; $display("FAIL byte_load: rd %h stall %0d want 000000ad 0", o.rd, o.stall_cyc); end
    endtask

    task automatic test_store_miss();
        obs_t e, o;
        predict(1, 32'h40, 32'h12345678, 0, 0, 2, e);
        do_access(1, 32'h40, 32'h12345678, 0, 0, 2, o);
        n_checks++; if (o.txns !== 1 || o.m_we !== 1'b1 || o.m_wdata !== 32'h12345678 || o.m_be !== 4'hF) begin
            n_fail++; $display("FAIL wstore: txns %0d we %b wdata %h be %b want 1 1 12345678 1111", o.txns, o.m_we, o.m_wdata, o.m_be); end
        n_checks++; if (o.stall_cyc !== 3) begin n_fail++; $display("FAIL wstore_stall: got %0d want 3", o.stall_cyc); end
        predict(0, 32'h40, 0, 0, 0, 0, e);
        do_access(0, 32'h40, 0, 0, 0, 0, o);
        n_checks++; if (o.txns !== 1 || o.stall_cyc !== 2) begin
            n_fail++; $display("FAIL no_allocate: txns %0d stall %0d want 1 2", o.txns, o.stall_cyc); end
        n_checks++; if (o.rd !== 32'h12345678) begin n_fail++; $display("FAIL no_allocate_rdata: got %h want 12345678", o.rd); end
    endtask

    task automatic test_invalidate();
        obs_t e, o;
        bus.invalidate = 1'b1;
        for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
        idle(1);
        bus.invalidate = 1'b0;
        predict(0, 32'h10, 0, 0, 0, 1, e);
        do_access(0, 32'h10, 0, 0, 0, 1, o);
        n_checks++; if (o.txns !== 1 || o.m_addr !== 32'h10 || o.stall_cyc !== 3) begin
            n_fail++; $display("FAIL inv_pulse: txns %0d addr %h stall %0d want 1 10 3", o.txns, o.m_addr, o.stall_cyc); end
        // invalidate alongside a load that would otherwise hit
        predict(0, 32'h10, 0, 0, 1, 1, e);
        do_access(0, 32'h10, 0, 0, 1, 1, o);
        n_checks++; if (o.txns !== 1 || o.stall_cyc !== 3) begin
            n_fail++; $display("FAIL inv_same_cycle: txns %0d stall %0d want 1 3", o.txns, o.stall_cyc); end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        bit seen;
        seen = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h30; bus.addr_mode = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            idle(1);
            #1;
            seen = bus.mem_req;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: got %b want 1", seen); end
        rst = 1'b1;
        idle(1);
        #1;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got %b want 0", bus.mem_req); end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        model_clear();
        idle(1);
        predict(0, 32'h10, 0, 0, 0, 1, e);
        do_access(0, 32'h10, 0, 0, 0, 1, o);
        n_checks++; if (o.txns !== 1 || o.stall_cyc !== 3) begin
            n_fail++; $display("FAIL rstmid_miss: txns %0d stall %0d want 1 3", o.txns, o.stall_cyc); end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        bit we, mode, inv;
        logic [31:0] addr, wd;
        int lat;
        for (int n = 0; n < 300; n++) begin
            we   = ($urandom_range(0, 2) == 0);
            mode = $urandom_range(0, 1);
            inv  = !we && ($urandom_range(0, 9) == 0);
            lat  = $urandom_range(0, 3);
            addr = ($urandom_range(0, 3) * 4 * SETS) + ($urandom_range(0, SETS - 1) * 4) + $urandom_range(0, 3);
            wd   = $urandom;
            predict(we, addr, wd, mode, inv, lat, e);
            do_access(we, addr, wd, mode, inv, lat, o);
            n_checks++; if (o.timeout) begin n_fail++; $display("FAIL rnd_timeout #%0d: addr %h", n, addr); end
            n_checks++; if (o.stall_cyc !== e.stall_cyc || o.txns !== e.txns) begin
                n_fail++; $display("FAIL rnd_stall #%0d addr %h we %b: stall %0d txns %0d want %0d %0d", n, addr, we, o.stall_cyc, o.txns, e.stall_cyc, e.txns); end
            if (!we) begin
                n_checks++; if (o.rd !== e.rd) begin
                    n_fail++; $display("FAIL rnd_rdata #%0d addr %h mode %b: got %h want %h", n, addr, mode, o.rd, e.rd); end
            end
            if (e.txns == 1) begin
                n_checks++; if (o.m_addr !== e.m_addr || o.m_be !== e.m_be || o.m_we !== e.m_we) begin
                    n_fail++; $display("FAIL rnd_memreq #%0d: addr %h be %b we %b want %h %b %b", n, o.m_addr, o.m_be, o.m_we, e.m_addr, e.m_be, e.m_we); end
            end
            if (we) begin
                n_checks++; if (o.m_wdata !== e.m_wdata) begin
                    n_fail++; $display("FAIL rnd_wdata #%0d: got %h want %h", n, o.m_wdata, e.m_wdata); end
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        n_checks++; if (access_count !== m_acc) begin n_fail++; $display("FAIL stats_access: got %0d want %0d", access_count, m_acc); end
        n_checks++; if (miss_count !== m_miss) begin n_fail++; $display("FAIL stats_miss: got %0d want %0d", miss_count, m_miss); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_read_miss();
        test_conflict();
        test_byte_store();
        test_store_miss();
        test_invalidate();
        test_reset_mid();
        test_back_to_back();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
